// File: rtl/register_share_arbiter.sv
// register_share_arbiter: round-robin arbiter for two requesters sharing one
// WIDTH-bit register, with bounded lock, per-load ack and a wrapping count.
//
// Ports:
//   ClkN       falling-edge clock
//   Clr        asynchronous active-high reset
//   Req0/Req1  access requests
//   Lock0/1    owner asks to keep the grant after the current load
//   D0/D1      write data per requester
//   Gnt0/1     registered grants (at most one high)
//   Ack0/1     one-cycle pulse: that requester's data was just loaded
//   Q          shared register contents
//   LoadCount  loads performed, modulo 256
//   LastOwner  most recent grantee, drives the round-robin tie break
module register_share_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             ClkN,
  input  logic             Clr,
  input  logic             Req0,
  input  logic             Req1,
  input  logic             Lock0,
  input  logic             Lock1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Ack0,
  output logic             Ack1,
  output logic [WIDTH-1:0] Q,
  output logic [7:0]       LoadCount,
  output logic             LastOwner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] HoldMax = 4'(MAX_HOLD);

  state_t           state;
  logic [3:0]       hold;

  // Owner-relative view so both OWN states share one body.
  logic             own;
  logic             req_own;
  logic             req_oth;
  logic             lock_own;
  logic [WIDTH-1:0] d_own;
  logic [3:0]       hold_inc;
  logic             keep;

  always_comb begin
    own      = (state == OWN1);
    req_own  = own ? Req1 : Req0;
    req_oth  = own ? Req0 : Req1;
    lock_own = own ? Lock1 : Lock0;
    d_own    = own ? D1 : D0;
    hold_inc = hold + 4'd1;
    // hold_inc never exceeds HoldMax: at the limit the
    // owner stays only if nobody else is waiting.
    keep     = req_own && lock_own &&
               ((hold_inc < HoldMax) || !req_oth);
  end

  always_ff @(negedge ClkN or posedge Clr) begin
    if (Clr) begin
      state     <= IDLE;
      Gnt0      <= 1'b0;
      Gnt1      <= 1'b0;
      Ack0      <= 1'b0;
      Ack1      <= 1'b0;
      Q         <= '0;
      LoadCount <= 8'd0;
      LastOwner <= 1'b1;
      hold      <= 4'd0;
    end else begin
      Ack0 <= 1'b0;
      Ack1 <= 1'b0;
      unique case (state)
        IDLE: begin
          hold <= 4'd0;
          if (Req0 && (!Req1 || LastOwner)) begin
            state     <= OWN0;
            Gnt0      <= 1'b1;
            Gnt1      <= 1'b0;
            LastOwner <= 1'b0;
          end else if (Req1) begin
            state     <= OWN1;
            Gnt0      <= 1'b0;
            Gnt1      <= 1'b1;
            LastOwner <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (req_own) begin
            Q         <= d_own;
            LoadCount <= LoadCount + 8'd1;
            Ack0      <= !own;
            Ack1      <= own;
          end
          if (keep) begin
            // Uncontested lock at the limit starts a new window.
            hold <= (hold_inc == HoldMax) ? 4'd0 : hold_inc;
          end else begin
            hold <= 4'd0;
            if (req_oth) begin
              state     <= own ? OWN0 : OWN1;
              Gnt0      <= own;
              Gnt1      <= !own;
              LastOwner <= !own;
            end else begin
              state <= IDLE;
              Gnt0  <= 1'b0;
              Gnt1  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          Gnt0  <= 1'b0;
          Gnt1  <= 1'b0;
          hold  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_share_arbiter.sv
// tb_register_share_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level model of the arbiter.
module tb_register_share_arbiter;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             ClkN = 1'b1;
  logic             Clr = 1'b1;
  logic             Req0 = 1'b0;
  logic             Req1 = 1'b0;
  logic             Lock0 = 1'b0;
  logic             Lock1 = 1'b0;
  logic [WIDTH-1:0] D0 = '0;
  logic [WIDTH-1:0] D1 = '0;
  logic             Gnt0, Gnt1, Ack0, Ack1;
  logic [WIDTH-1:0] Q;
  logic [7:0]       LoadCount;
  logic             LastOwner;

  int tests = 0;
  int fails = 0;

  register_share_arbiter #(
    .WIDTH(WIDTH),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .ClkN(ClkN),
    .Clr(Clr),
    .Req0(Req0),
    .Req1(Req1),
    .Lock0(Lock0),
    .Lock1(Lock1),
    .D0(D0),
    .D1(D1),
    .Gnt0(Gnt0),
    .Gnt1(Gnt1),
    .Ack0(Ack0),
    .Ack1(Ack1),
    .Q(Q),
    .LoadCount(LoadCount),
    .LastOwner(LastOwner)
  );

  always #5 ClkN = ~ClkN;

  // Reference model: owner index (-1 = nobody), loads in this tenure.
  bit             model_on = 0;
  int             m_own;
  bit             m_last;
  int             m_hold;
  logic [7:0]     m_q;
  logic [7:0]     m_cnt;
  bit             m_ack[2];

  function automatic void m_reset();
    m_own = -1;
    m_last = 1;
    m_hold = 0;
    m_q = 0;
    m_cnt = 0;
    m_ack[0] = 0;
    m_ack[1] = 0;
  endfunction

  function automatic void m_handover(bit r[2], int y);
    m_hold = 0;
    if (r[y]) begin
      m_own = y;
      m_last = y[0];
    end else begin
      m_own = -1;
    end
  endfunction

  function automatic void model_step();
    bit r[2];
    bit l[2];
    logic [7:0] d[2];
    int x, y;
    r[0] = Req0; r[1] = Req1;
    l[0] = Lock0; l[1] = Lock1;
    d[0] = D0; d[1] = D1;
    m_ack[0] = 0;
    m_ack[1] = 0;
    if (m_own < 0) begin
      m_hold = 0;
      if (r[0] && r[1]) begin
        m_own = m_last ? 0 : 1;
        m_last = !m_last;
      end else if (r[0]) begin
        m_own = 0; m_last = 0;
      end else if (r[1]) begin
        m_own = 1; m_last = 1;
      end
    end else begin
      x = m_own;
      y = 1 - x;
      if (r[x]) begin
        m_q = d[x];
        m_cnt = m_cnt + 8'd1;
        m_ack[x] = 1;
        m_hold = m_hold + 1;
        if (l[x] && m_hold < MAX_HOLD) begin
        end else if (l[x] && !r[y]) begin
          m_hold = 0;
        end else begin
          m_handover(r, y);
        end
      end else begin
        m_handover(r, y);
      end
    end
  endfunction

  task automatic tick();
    @(negedge ClkN);
    if (model_on) model_step();
    @(posedge ClkN);
  endtask

  task automatic pulse_clr();
    Clr = 1'b1;
    #2;
    Clr = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] d);
    Req0 = 1'b1;
    D0 = d;
    tick();
    tick();
    Req0 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge ClkN);
    tests++;
    if ({Gnt0, Gnt1, Ack0, Ack1} !== 4'b0 || Q !== 8'h00 ||
        LoadCount !== 8'd0 || LastOwner !== 1'b1) begin
      fails++;
      $display("FAIL reset_init got g%b%b a%b%b q%h c%0d lo%b",
               Gnt0, Gnt1, Ack0, Ack1, Q, LoadCount, LastOwner);
    end
    Clr = 1'b0;
    for (int i = 0; i < 16; i++) do_load(8'($urandom));
    do_load(8'hA5);
    tests++;
    if (Q !== 8'hA5 || LoadCount !== 8'd17) begin
      fails++;
      $display("FAIL reset_pre got q%h c%0d want a5 17", Q, LoadCount);
    end
    Req0 = 1'b1;
    D0 = 8'h99;
    tick();
    tests++;
    if (Gnt0 !== 1'b1) begin
      fails++;
      $display("FAIL reset_gnt got %b want 1", Gnt0);
    end
    Clr = 1'b1;
    #1;
    tests++;
    if ({Gnt0, Gnt1, Ack0, Ack1} !== 4'b0 || Q !== 8'h00 ||
        LoadCount !== 8'd0 || LastOwner !== 1'b1) begin
      fails++;
      $display("FAIL reset_async got g%b%b a%b%b q%h c%0d lo%b",
               Gnt0, Gnt1, Ack0, Ack1, Q, LoadCount, LastOwner);
    end
    Clr = 1'b0;
    Req0 = 1'b0;
    tick();
    tests++;
    if (Ack0 !== 1'b0 || Q !== 8'h00 || Gnt0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_after got a%b q%h g%b want 0 00 0",
               Ack0, Q, Gnt0);
    end
  endtask

  task automatic test_single();
    pulse_clr();
    Req0 = 1'b1;
    D0 = 8'h3C;
    tick();
    tests++;
    if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0 || Ack0 !== 1'b0 ||
        Q !== 8'h00) begin
      fails++;
      $display("FAIL single_gnt got g%b%b a%b q%h want 10 0 00",
               Gnt0, Gnt1, Ack0, Q);
    end
    tick();
    Req0 = 1'b0;
    tests++;
    if (Q !== 8'h3C || Ack0 !== 1'b1 || Gnt0 !== 1'b0 ||
        LoadCount !== 8'd1) begin
      fails++;
      $display("FAIL single_load got q%h a%b g%b c%0d want 3c 1 0 1",
               Q, Ack0, Gnt0, LoadCount);
    end
    tick();
    tests++;
    if (Ack0 !== 1'b0 || Q !== 8'h3C) begin
      fails++;
      $display("FAIL single_ackclr got a%b q%h want 0 3c", Ack0, Q);
    end
  endtask

  task automatic test_tie();
    logic [7:0] want;
    pulse_clr();
    Req0 = 1'b1;
    Req1 = 1'b1;
    D0 = 8'h11;
    D1 = 8'h22;
    tick();
    tests++;
    if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0) begin
      fails++;
      $display("FAIL tie_first got g%b%b want 10", Gnt0, Gnt1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      want = (i % 2 == 0) ? 8'h11 : 8'h22;
      tests++;
      if (Q !== want || Ack0 !== (i % 2 == 0) ||
          Ack1 !== (i % 2 == 1) || Gnt0 !== (i % 2 == 1) ||
          Gnt1 !== (i % 2 == 0)) begin
        fails++;
        $display("FAIL tie_seq%0d got q%h a%b%b g%b%b want q%h",
                 i, Q, Ack0, Ack1, Gnt0, Gnt1, want);
      end
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
    tick();
  endtask

  task automatic test_lock();
    pulse_clr();
    Req0 = 1'b1;
    Lock0 = 1'b1;
    Req1 = 1'b1;
    D1 = 8'hE1;
    tick();
    for (int i = 0; i < MAX_HOLD; i++) begin
      D0 = 8'(8'h40 + i);
      tick();
      tests++;
      if (Ack0 !== 1'b1 || Ack1 !== 1'b0 || Q !== 8'(8'h40 + i) ||
          Gnt0 !== (i != MAX_HOLD - 1) ||
          Gnt1 !== (i == MAX_HOLD - 1)) begin
        fails++;
        $display("FAIL lock_hold%0d got a%b%b g%b%b q%h",
                 i, Ack0, Ack1, Gnt0, Gnt1, Q);
      end
    end
    tick();
    tests++;
    if (Ack1 !== 1'b1 || Ack0 !== 1'b0 || Q !== 8'hE1) begin
      fails++;
      $display("FAIL lock_handover got a%b%b q%h want 01 e1",
               Ack0, Ack1, Q);
    end
    Req1 = 1'b0;
    Req0 = 1'b0;
    Lock0 = 1'b0;
    tick();
    pulse_clr();
    Req0 = 1'b1;
    Lock0 = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      D0 = 8'($urandom);
      tick();
      tests++;
      if (Ack0 !== 1'b1 || Gnt0 !== 1'b1 || Q !== D0) begin
        fails++;
        $display("FAIL lock_solo%0d got a%b g%b q%h want 1 1 %h",
                 i, Ack0, Gnt0, Q, D0);
      end
    end
    Req0 = 1'b0;
    Lock0 = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    pulse_clr();
    do_load(8'h5A);
    Req1 = 1'b1;
    D1 = 8'h77;
    tick();
    tests++;
    if (Gnt1 !== 1'b1) begin
      fails++;
      $display("FAIL wd_gnt1 got %b want 1", Gnt1);
    end
    Req1 = 1'b0;
    Req0 = 1'b1;
    tick();
    tests++;
    if (Ack1 !== 1'b0 || Ack0 !== 1'b0 || Q !== 8'h5A ||
        Gnt0 !== 1'b1 || Gnt1 !== 1'b0 || LoadCount !== 8'd1) begin
      fails++;
      $display("FAIL wd_edge got a%b%b q%h g%b%b c%0d",
               Ack0, Ack1, Q, Gnt0, Gnt1, LoadCount);
    end
    Req0 = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    pulse_clr();
    d = 8'h00;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      do_load(d);
    end
    tests++;
    if (LoadCount !== 8'h00 || Q !== d) begin
      fails++;
      $display("FAIL wrap_256 got c%h q%h want 00 %h", LoadCount, Q, d);
    end
    do_load(8'hC3);
    tests++;
    if (LoadCount !== 8'h01 || Q !== 8'hC3) begin
      fails++;
      $display("FAIL wrap_257 got c%h q%h want 01 c3", LoadCount, Q);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    m_reset();
    model_on = 1;
    pulse_clr();
    for (int i = 0; i < 3000; i++) begin
      Req0 = ($urandom_range(0, 3) != 0);
      Req1 = ($urandom_range(0, 3) != 0);
      Lock0 = $urandom_range(0, 1) != 0;
      Lock1 = $urandom_range(0, 2) == 0;
      D0 = 8'($urandom);
      D1 = 8'($urandom);
      tick();
      tests++;
      if (Gnt0 !== (m_own == 0) || Gnt1 !== (m_own == 1) ||
          Ack0 !== m_ack[0] || Ack1 !== m_ack[1] || Q !== m_q ||
          LoadCount !== m_cnt || LastOwner !== m_last) begin
        fails++;
        bad++;
        if (bad <= 10)
          $display("FAIL rand%0d got g%b%b a%b%b q%h c%0d lo%b want g%b%b a%b%b q%h c%0d lo%b",
                   i, Gnt0, Gnt1, Ack0, Ack1, Q, LoadCount, LastOwner,
                   m_own == 0, m_own == 1, m_ack[0], m_ack[1], m_q,
                   m_cnt, m_last);
      end
    end
    model_on = 0;
    Req0 = 1'b0;
    Req1 = 1'b0;
    Lock0 = 1'b0;
    Lock1 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_lock();
    test_withdraw();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_share_arbiter.md
# register_share_arbiter

Arbitrates two requesters for a shared, internally held WIDTH-bit load-enabled register. Grants use a round-robin policy with an optional bounded lock for back-to-back loads. Each accepted write is acknowledged, and a wrapping count of loads is kept. The block sits between bus-side requesters and the team's negative-edge register datapath, and replaces ad-hoc load-enable gating.

## Interface
- WIDTH, 8, data width of the shared register and of each requester's data input
- MAX_HOLD, 4, maximum consecutive loads one owner may perform under Lock while the other requester waits (range 1..15)

- ClkN  input  1  clock; all state updates on the falling edge
- Clr  input  1  asynchronous, active-high reset
- Req0, Req1  input  1 each  requester wants access; held high until Ack or voluntary withdrawal
- Lock0, Lock1  input  1 each  owner requests to keep the grant after the current load
- D0, D1  input  WIDTH each  write data from requester 0 / 1
- Gnt0, Gnt1  output  1 each  registered grant; at most one high
- Ack0, Ack1  output  1 each  one-cycle registered pulse: the requester's data was loaded at the preceding falling edge
- Q  output  WIDTH  contents of the shared register
- LoadCount  output  8  number of loads performed, modulo 256
- LastOwner  output  1  index of the most recent grantee; used for round-robin

## Operation
- States: IDLE, OWN0, OWN1. Gnt0 = (state==OWN0), Gnt1 = (state==OWN1), both registered.
- Reset (Clr=1, any time, asynchronous):
  - State = IDLE; Gnt0 = Gnt1 = 0; Ack0 = Ack1 = 0.
  - Q = 0; LoadCount = 0; LastOwner = 1, so requester 0 wins the first tie; hold counter = 0.
- IDLE:
  - Only Reqx high: go to OWNx and set LastOwner = x.
  - Both high: grant !LastOwner.
  - Neither high: stay in IDLE.
  - No load happens in IDLE.
- OWNx with Reqx=1, on each falling edge:
  - Q <= Dx; Ackx <= 1; LoadCount++ (wraps 255 -> 0); hold++.
- OWNx, release decision on the same edge as a load:
  - Keep OWNx if Lockx=1 and hold < MAX_HOLD.
  - Keep OWNx if Lockx=1, hold == MAX_HOLD and Reqy=0; hold resets to 0.
  - Otherwise release: go to OWNy if Reqy=1 (hold=0, LastOwner=y), else IDLE.
- OWNx with Reqx=0 (withdrawal): no load and no Ack. Go to OWNy if Reqy=1, else IDLE.
- Hold counter: 4 bits; cleared on every new grant and on IDLE entry.
- Ack is cleared on the next edge unless another load occurs. It is never asserted for the non-owner.
- Requester duty: deassert Reqx on the cycle after Ackx unless Lockx is also held. Lock without Req is ignored.

## Timing
- Latency from an idle block:
  - Req sampled at edge N.
  - Gnt high after edge N.
  - Load and Q update at edge N+1.
  - Ack high from N+1 to N+2.
- Grant handover to a waiting requester is direct (OWNx -> OWNy in one edge), with no IDLE bubble. The waiting requester loads one edge after the releasing owner's last load.
- Sustained contention without Lock: loads alternate 0,1,0,1 with one load per cycle.
- Lock with contention: the owner gets exactly MAX_HOLD consecutive loads, then must hand over.
- Clr asserted mid-tenure: Q returns to 0 immediately and the load in progress is lost, with no Ack. After Clr falls, the first grant needs a fresh IDLE arbitration edge.
- D0/D1 must be stable around the falling edge of ClkN. Q changes only on falling edges or on Clr.

## Test plan
- Reset: Clr pulse mid-run with Q=0xA5 and LoadCount=17 -> Q=0x00, LoadCount=0, Gnt=00, Ack=00 immediately, without waiting for a clock edge.
- Single requester: Req0=1 with D0=0x3C at edge 0 -> Gnt0 after edge 0; Q=0x3C and Ack0=1 after edge 1; state IDLE after edge 1 (Lock0=0).
- Tie from reset: Req0 = Req1 = 1 held, D0=0x11, D1=0x22 -> Gnt0 first; Q sequence 0x11, 0x22, 0x11, 0x22; Gnt toggles every cycle with no IDLE gap.
- Lock limit: Req0 = Lock0 = 1 and Req1 = 1, MAX_HOLD=4 -> exactly 4 consecutive Ack0 pulses, then Gnt1 and one Ack1. With Req1=0 instead, owner 0 keeps loading indefinitely.
- Withdrawal: Gnt1 high, Req1 dropped before the load edge while Req0=1 -> no Ack1, Q unchanged, Gnt0 after that edge.
- Wrap: 256 single-requester loads -> LoadCount returns to 0x00. Load 257 -> 0x01.
